// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO.
// Shift-add multiply and restoring divide, one bit per cycle.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX
  } state_t;

  state_t             state_q, state_d;
  logic               div_q, div_d;
  logic               sa_q, sa_d;
  logic               sb_q, sb_d;
  logic [WIDTH-1:0]   amag_q, amag_d;
  logic [WIDTH-1:0]   bmag_q, bmag_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               in_sa, in_sb;
  logic [WIDTH-1:0]   in_amag, in_bmag;
  logic [WIDTH:0]     msum;
  logic [WIDTH:0]     shifted;
  logic [WIDTH:0]     trial;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rmd;

  // Signed ops work on magnitudes; op[0]=0 marks the signed forms.
  assign in_sa   = ~op[0] & a[WIDTH-1];
  assign in_sb   = ~op[0] & b[WIDTH-1];
  assign in_amag = in_sa ? -a : a;
  assign in_bmag = in_sb ? -b : b;

  // Multiply step: add multiplicand to upper half if LSB set.
  assign msum = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
              + (acc_q[0] ? {1'b0, amag_q} : '0);

  // Divide step: borrow of the trial subtract lands in bit WIDTH.
  assign shifted = {rem_q, acc_q[WIDTH-1]};
  assign trial   = shifted - {1'b0, bmag_q};

  // Sign fix-up; b==0 leaves rem=|a|, so hi naturally becomes a.
  assign prod = (sa_q ^ sb_q) ? -acc_q : acc_q;
  assign quo  = (sa_q ^ sb_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rmd  = sa_q ? -rem_q : rem_q;

  // Next-state and datapath for IDLE -> RUN -> FIX -> IDLE.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    amag_d  = amag_q;
    bmag_d  = bmag_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          div_d   = op[1];
          sa_d    = in_sa;
          sb_d    = in_sb;
          amag_d  = in_amag;
          bmag_d  = in_bmag;
          acc_d   = op[1] ? {{WIDTH{1'b0}}, in_amag}
                          : {{WIDTH{1'b0}}, in_bmag};
          rem_d   = '0;
          cnt_d   = CW'(WIDTH - 1);
          busy_d  = 1'b1;
          state_d = RUN;
        end else begin
          if (mthi) hi_d = wdata;
          if (mtlo) lo_d = wdata;
        end
      end
      RUN: begin
        if (div_q) begin
          rem_d = trial[WIDTH] ? shifted[WIDTH-1:0]
                               : trial[WIDTH-1:0];
          acc_d = {acc_q[2*WIDTH-1:WIDTH],
                   acc_q[WIDTH-2:0], ~trial[WIDTH]};
        end else begin
          acc_d = {msum, acc_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) state_d = FIX;
      end
      FIX: begin
        if (div_q) begin
          hi_d = rmd;
          lo_d = (bmag_q == '0) ? '1 : quo;
        end else begin
          hi_d = prod[2*WIDTH-1:WIDTH];
          lo_d = prod[WIDTH-1:0];
        end
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      div_q   <= 1'b0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      amag_q  <= '0;
      bmag_q  <= '0;
      acc_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      amag_q  <= amag_d;
      bmag_q  <= bmag_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
